// File: rtl/fpu_seq_pkg.sv
// rtl/fpu_seq_pkg.sv - state encoding, register map and op check for the FPU command sequencer
package fpu_seq_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLR_IRQ,
      S_WR_FRM,
      S_WR_A,
      S_WR_B,
      S_WR_C,
      S_WR_OP,
      S_CLR_OP,
      S_WAIT,
      S_RD_IRQ,
      S_RD_RES,
      S_RD_FLG,
      S_RESP
   } state_t;

   localparam logic [31:0] OFF_A      = 32'h00;
   localparam logic [31:0] OFF_B      = 32'h04;
   localparam logic [31:0] OFF_C      = 32'h08;
   localparam logic [31:0] OFF_RESULT = 32'h0C;
   localparam logic [31:0] OFF_OPCOMP = 32'h10;
   localparam logic [31:0] OFF_INTR   = 32'h14;
   localparam logic [31:0] OFF_OP     = 32'h1C;
   localparam logic [31:0] OFF_FFLAGS = 32'h20;
   localparam logic [31:0] OFF_FRM    = 32'h24;
   localparam logic [31:0] OFF_FCSR   = 32'h28;

   localparam logic [12:0] OP_LEGAL_MASK = 13'h1FFC;

   // An op is legal only when exactly one bit is set and that bit lies inside the mask.
   function automatic logic op_is_legal(input logic [12:0] op);
      return ((op & ~OP_LEGAL_MASK) == 13'd0) && $onehot(op);
   endfunction

endpackage

// File: rtl/fpu_cmd_sequencer.sv
// rtl/fpu_cmd_sequencer.sv - runs one FPU register transaction per accepted job and returns result/flags
module fpu_cmd_sequencer
   import fpu_seq_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter int          CNT_W          = 16
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_opa,
   input  logic [31:0] cmd_opb,
   input  logic [31:0] cmd_opc,
   input  logic [12:0] cmd_op,
   input  logic [2:0]  cmd_frm,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [4:0]  rsp_fflags,
   output logic        rsp_timeout,
   output logic        rsp_error,
   output logic [31:0] addr,
   output logic        wren,
   output logic [31:0] wrdata,
   input  logic [31:0] rddata,
   input  logic        inter_gen,
   output logic        busy
);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] wait_cnt;
   logic [31:0]      opa_q;
   logic [31:0]      opb_q;
   logic [31:0]      opc_q;
   logic [12:0]      op_q;
   logic [2:0]       frm_q;
   logic             accept;
   logic             wait_expired;
   logic [31:0]      addr_d;
   logic             wren_d;
   logic [31:0]      wrdata_d;

   assign accept       = cmd_valid && (state_q == S_IDLE);
   assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign cmd_ready    = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign rsp_valid    = (state_q == S_RESP);

   // State register.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: fixed register sequence, with WAIT exiting on interrupt or timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (accept) state_d = op_is_legal(cmd_op) ? S_CLR_IRQ : S_RESP;
         S_CLR_IRQ: state_d = S_WR_FRM;
         S_WR_FRM:  state_d = S_WR_A;
         S_WR_A:    state_d = S_WR_B;
         S_WR_B:    state_d = S_WR_C;
         S_WR_C:    state_d = S_WR_OP;
         S_WR_OP:   state_d = S_CLR_OP;
         S_CLR_OP:  state_d = S_WAIT;
         S_WAIT: begin
            if (inter_gen) begin
               state_d = S_RD_IRQ;
            end else if (wait_expired) begin
               state_d = S_RESP;
            end
         end
         S_RD_IRQ:  state_d = S_RD_RES;
         S_RD_RES:  state_d = S_RD_FLG;
         S_RD_FLG:  state_d = S_RESP;
         S_RESP:    if (rsp_ready) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Bus access for the state being entered, so the registered bus lines up with the state.
   always_comb begin
      addr_d   = 32'd0;
      wren_d   = 1'b0;
      wrdata_d = 32'd0;
      case (state_d)
         S_CLR_IRQ, S_RD_IRQ: addr_d = BASE_ADDR + OFF_INTR;
         S_WR_FRM: begin
            addr_d   = BASE_ADDR + OFF_FRM;
            wren_d   = 1'b1;
            wrdata_d = {29'd0, frm_q};
         end
         S_WR_A: begin
            addr_d   = BASE_ADDR + OFF_A;
            wren_d   = 1'b1;
            wrdata_d = opa_q;
         end
         S_WR_B: begin
            addr_d   = BASE_ADDR + OFF_B;
            wren_d   = 1'b1;
            wrdata_d = opb_q;
         end
         S_WR_C: begin
            addr_d   = BASE_ADDR + OFF_C;
            wren_d   = 1'b1;
            wrdata_d = opc_q;
         end
         S_WR_OP: begin
            addr_d   = BASE_ADDR + OFF_OP;
            wren_d   = 1'b1;
            wrdata_d = {19'd0, op_q};
         end
         S_CLR_OP: begin
            addr_d   = BASE_ADDR + OFF_OP;
            wren_d   = 1'b1;
         end
         S_RD_RES:  addr_d = BASE_ADDR + OFF_RESULT;
         S_RD_FLG:  addr_d = BASE_ADDR + OFF_FFLAGS;
         default: begin
            addr_d   = 32'd0;
            wren_d   = 1'b0;
            wrdata_d = 32'd0;
         end
      endcase
   end

   // Registered bus outputs; idle value is addr=0 which lies outside the register map.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         addr   <= 32'd0;
         wren   <= 1'b0;
         wrdata <= 32'd0;
      end else begin
         addr   <= addr_d;
         wren   <= wren_d;
         wrdata <= wrdata_d;
      end
   end

   // WAIT cycle counter, held at zero outside WAIT so every entry starts fresh.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wait_cnt <= '0;
      end else if (state_q == S_WAIT) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   // Job latch on acceptance and response capture from the read-back cycles.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         opa_q       <= 32'd0;
         opb_q       <= 32'd0;
         opc_q       <= 32'd0;
         op_q        <= 13'd0;
         frm_q       <= 3'd0;
         rsp_result  <= 32'd0;
         rsp_fflags  <= 5'd0;
         rsp_timeout <= 1'b0;
         rsp_error   <= 1'b0;
      end else begin
         if (accept) begin
            opa_q       <= cmd_opa;
            opb_q       <= cmd_opb;
            opc_q       <= cmd_opc;
            op_q        <= cmd_op;
            frm_q       <= cmd_frm;
            rsp_result  <= 32'd0;
            rsp_fflags  <= 5'd0;
            rsp_timeout <= 1'b0;
            rsp_error   <= !op_is_legal(cmd_op);
         end
         if (state_q == S_RD_RES) begin
            rsp_result <= rddata;
         end
         if (state_q == S_RD_FLG) begin
            rsp_fflags <= rddata[4:0];
         end
         if ((state_q == S_WAIT) && !inter_gen && wait_expired) begin
            rsp_timeout <= 1'b1;
         end
      end
   end

endmodule
